// File: rtl/hall_call_dispatcher.sv
// Purpose: latch hall calls into a pend/asgn scoreboard, scan it round-robin and offer each call to the nearest idle car.
// Latency: scan hit -> PICK next cycle -> assign_valid two cycles after the hit; worst case latch to offer is 22 scan cycles + 2.
// Backpressure: an offer is held until the target car's ready bit is seen, the slot is cleared, or TIMEOUT cycles expire.
module hall_call_dispatcher #(
    parameter int NUM_FLOORS = 11,
    parameter int NUM_LIFTS  = 4,
    parameter int TIMEOUT    = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_FLOORS-1:0]        hall_up,
    input  logic [NUM_FLOORS-1:0]        hall_dn,
    input  logic [NUM_FLOORS-1:0]        clear_up,
    input  logic [NUM_FLOORS-1:0]        clear_dn,
    input  logic [4*NUM_LIFTS-1:0]       lift_floor,
    input  logic [NUM_LIFTS-1:0]         lift_idle,
    input  logic [NUM_LIFTS-1:0]         assign_ready,
    output logic                         assign_valid,
    output logic [$clog2(NUM_LIFTS)-1:0] assign_lift,
    output logic [3:0]                   assign_floor,
    output logic                         assign_dir,
    output logic [NUM_FLOORS-1:0]        pend_up,
    output logic [NUM_FLOORS-1:0]        pend_dn,
    output logic                         timeout_err
);

    localparam int NS = 2 * NUM_FLOORS;
    localparam int PW = $clog2(NS);
    localparam int LW = $clog2(NUM_LIFTS);
    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        ST_SCAN  = 2'd0,
        ST_PICK  = 2'd1,
        ST_OFFER = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [PW-1:0]   ptr_q, ptr_d;
    logic [PW-1:0]   slot_q, slot_d;
    logic [LW-1:0]   lift_q, lift_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            terr_q, terr_d;
    logic [NS-1:0]   pend_q, pend_d;
    logic [NS-1:0]   asgn_q, asgn_d;

    logic [NS-1:0]   set_m;
    logic [NS-1:0]   clr_m;
    logic [PW-1:0]   ptr_inc;
    logic [3:0]      slot_floor;
    logic            best_vld;
    logic [LW-1:0]   best_lift;
    logic [3:0]      best_dist;
    logic            accept;

    assign ptr_inc    = (ptr_q == PW'(NS - 1)) ? '0 : ptr_q + 1'b1;
    assign slot_floor = 4'(slot_q >> 1);

    // Map buttons and clears onto slot masks; up at the top floor and down at the bottom floor cannot exist.
    always_comb begin
        set_m = '0;
        clr_m = '0;
        for (int f = 0; f < NUM_FLOORS; f++) begin
            set_m[2*f+1] = hall_up[f] && (f != NUM_FLOORS - 1);
            set_m[2*f]   = hall_dn[f] && (f != 0);
            clr_m[2*f+1] = clear_up[f];
            clr_m[2*f]   = clear_dn[f];
        end
    end

    // Nearest idle car to the latched call; strict less-than keeps the lowest index on a tie.
    always_comb begin
        logic [3:0] car_floor;
        logic [3:0] car_dist;
        car_floor = '0;
        car_dist  = '0;
        best_vld  = 1'b0;
        best_lift = '0;
        best_dist = '0;
        for (int k = 0; k < NUM_LIFTS; k++) begin
            car_floor = lift_floor[4*k +: 4];
            car_dist  = (car_floor >= slot_floor) ? car_floor - slot_floor : slot_floor - car_floor;
            if (lift_idle[k] && (car_floor <= 4'(NUM_FLOORS - 1)) &&
                (!best_vld || (car_dist < best_dist))) begin
                best_vld  = 1'b1;
                best_lift = LW'(k);
                best_dist = car_dist;
            end
        end
    end

    // Scan/pick/offer sequencing; every exit from PICK or OFFER moves the pointer past the handled slot.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        slot_d  = slot_q;
        lift_d  = lift_q;
        cnt_d   = cnt_q;
        terr_d  = 1'b0;
        accept  = 1'b0;
        case (state_q)
            ST_SCAN: begin
                if (pend_q[ptr_q] && !asgn_q[ptr_q]) begin
                    slot_d  = ptr_q;
                    state_d = ST_PICK;
                end else begin
                    ptr_d = ptr_inc;
                end
            end
            ST_PICK: begin
                if (best_vld) begin
                    lift_d  = best_lift;
                    cnt_d   = CW'(1);
                    state_d = ST_OFFER;
                end else begin
                    ptr_d   = ptr_inc;
                    state_d = ST_SCAN;
                end
            end
            ST_OFFER: begin
                if (clr_m[slot_q]) begin
                    ptr_d   = ptr_inc;
                    state_d = ST_SCAN;
                end else if (assign_ready[lift_q]) begin
                    accept  = 1'b1;
                    ptr_d   = ptr_inc;
                    state_d = ST_SCAN;
                end else if (cnt_q == CW'(TIMEOUT)) begin
                    terr_d  = 1'b1;
                    ptr_d   = ptr_inc;
                    state_d = ST_SCAN;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_SCAN;
            end
        endcase
    end

    // Scoreboard update; a clear beats both a new button press and an accept in the same cycle.
    always_comb begin
        pend_d = (pend_q | set_m) & ~clr_m;
        asgn_d = asgn_q;
        if (accept) begin
            asgn_d[slot_q] = 1'b1;
        end
        asgn_d = asgn_d & ~clr_m;
    end

    // State and scoreboard registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_SCAN;
            ptr_q   <= '0;
            slot_q  <= '0;
            lift_q  <= '0;
            cnt_q   <= '0;
            terr_q  <= 1'b0;
            pend_q  <= '0;
            asgn_q  <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            slot_q  <= slot_d;
            lift_q  <= lift_d;
            cnt_q   <= cnt_d;
            terr_q  <= terr_d;
            pend_q  <= pend_d;
            asgn_q  <= asgn_d;
        end
    end

    // Offer fields read zero whenever no offer is present.
    always_comb begin
        assign_valid = (state_q == ST_OFFER);
        assign_lift  = assign_valid ? lift_q : '0;
        assign_floor = assign_valid ? slot_floor : 4'd0;
        assign_dir   = assign_valid && slot_q[0];
        timeout_err  = terr_q;
        for (int f = 0; f < NUM_FLOORS; f++) begin
            pend_up[f] = pend_q[2*f+1];
            pend_dn[f] = pend_q[2*f];
        end
    end

endmodule

// File: tb/tb_hall_call_dispatcher.sv
// Purpose: self-checking bench for hall_call_dispatcher against a slot-array reference model.
// Latency: the model advances at each rising edge; outputs are compared 1 time unit later.
// Backpressure: every wait on an offer is bounded; an expired bound is reported as a failed check.
module tb_hall_call_dispatcher;

    logic        clk;
    logic        rst;
    logic [10:0] hall_up, hall_dn, clear_up, clear_dn;
    logic [15:0] lift_floor;
    logic [3:0]  lift_idle, assign_ready;
    logic        assign_valid;
    logic [1:0]  assign_lift;
    logic [3:0]  assign_floor;
    logic        assign_dir;
    logic [10:0] pend_up, pend_dn;
    logic        timeout_err;

    int n_chk  = 0;
    int n_pass = 0;

    // Reference model: calls held per (floor, direction) slot, plus the current offer.
    bit m_pend[22];
    bit m_asgn[22];
    int m_ptr;
    int m_phase;   // 0 scanning, 1 choosing a car, 2 offering
    int m_slot;
    int m_lift;
    int m_cnt;
    bit m_terr;

    hall_call_dispatcher dut (
        .clk          (clk),
        .rst          (rst),
        .hall_up      (hall_up),
        .hall_dn      (hall_dn),
        .clear_up     (clear_up),
        .clear_dn     (clear_dn),
        .lift_floor   (lift_floor),
        .lift_idle    (lift_idle),
        .assign_ready (assign_ready),
        .assign_valid (assign_valid),
        .assign_lift  (assign_lift),
        .assign_floor (assign_floor),
        .assign_dir   (assign_dir),
        .pend_up      (pend_up),
        .pend_dn      (pend_dn),
        .timeout_err  (timeout_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    function automatic logic [10:0] sparse(input int pct);
        logic [10:0] b;
        for (int i = 0; i < 11; i++) b[i] = ($urandom_range(0, 99) < pct);
        return b;
    endfunction

    task automatic model_edge();
        bit clr[22];
        bit setb[22];
        int best, bd, lf, d, f;
        m_terr = 1'b0;
        if (rst) begin
            for (int s = 0; s < 22; s++) begin
                m_pend[s] = 1'b0;
                m_asgn[s] = 1'b0;
            end
            m_ptr = 0; m_phase = 0; m_slot = 0; m_lift = 0; m_cnt = 0;
            return;
        end
        for (int s = 0; s < 22; s++) begin
            f = s / 2;
            if (s % 2 == 1) begin
                clr[s]  = clear_up[f];
                setb[s] = hall_up[f] && (f != 10);
            end else begin
                clr[s]  = clear_dn[f];
                setb[s] = hall_dn[f] && (f != 0);
            end
        end
        if (m_phase == 0) begin
            if (m_pend[m_ptr] && !m_asgn[m_ptr]) begin
                m_slot  = m_ptr;
                m_phase = 1;
            end else begin
                m_ptr = (m_ptr + 1) % 22;
            end
        end else if (m_phase == 1) begin
            best = -1;
            bd   = 1000;
            f    = m_slot / 2;
            for (int k = 0; k < 4; k++) begin
                lf = int'(lift_floor[4*k +: 4]);
                d  = (lf > f) ? lf - f : f - lf;
                if (lift_idle[k] && lf <= 10 && d < bd) begin
                    bd   = d;
                    best = k;
                end
            end
            if (best >= 0) begin
                m_lift  = best;
                m_cnt   = 1;
                m_phase = 2;
            end else begin
                m_ptr   = (m_ptr + 1) % 22;
                m_phase = 0;
            end
        end else begin
            if (clr[m_slot]) begin
                m_phase = 0;
                m_ptr   = (m_ptr + 1) % 22;
            end else if (assign_ready[m_lift]) begin
                m_asgn[m_slot] = 1'b1;
                m_phase = 0;
                m_ptr   = (m_ptr + 1) % 22;
            end else if (m_cnt == 16) begin
                m_terr  = 1'b1;
                m_phase = 0;
                m_ptr   = (m_ptr + 1) % 22;
            end else begin
                m_cnt++;
            end
        end
        for (int s = 0; s < 22; s++) begin
            m_pend[s] = (m_pend[s] || setb[s]) && !clr[s];
            m_asgn[s] = m_asgn[s] && !clr[s];
        end
    endtask

    task automatic compare_model();
        logic [10:0] eu, ed;
        bit offer;
        for (int f = 0; f < 11; f++) begin
            eu[f] = m_pend[2*f+1];
            ed[f] = m_pend[2*f];
        end
        offer = (m_phase == 2);
        chk_eq("m_valid", assign_valid, offer);
        chk_eq("m_lift",  assign_lift,  offer ? m_lift : 0);
        chk_eq("m_floor", assign_floor, offer ? m_slot / 2 : 0);
        chk_eq("m_dir",   assign_dir,   offer ? m_slot % 2 : 0);
        chk_eq("m_pend_up", pend_up, eu);
        chk_eq("m_pend_dn", pend_dn, ed);
        chk_eq("m_terr",  timeout_err, m_terr);
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        compare_model();
    endtask

    task automatic quiet_inputs();
        hall_up = '0; hall_dn = '0; clear_up = '0; clear_dn = '0;
        lift_floor = '0; lift_idle = '0; assign_ready = '0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        quiet_inputs();
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic wait_valid(input string tag, input int budget);
        int n;
        n = 0;
        while (!assign_valid && n < budget) begin
            tick();
            n++;
        end
        chk_eq(tag, assign_valid, 1'b1);
    endtask

    initial begin
        int vcnt, tcnt;
        int mode;
        rst = 1'b1;
        quiet_inputs();

        // Reset state
        do_reset();
        chk_eq("rst_valid", assign_valid, 1'b0);
        chk_eq("rst_pend_up", pend_up, 11'h0);
        chk_eq("rst_pend_dn", pend_dn, 11'h0);
        chk_eq("rst_terr", timeout_err, 1'b0);

        // Single call: down at floor 7, cars at 0/3/9/10, car 2 nearest
        do_reset();
        lift_floor = {4'd10, 4'd9, 4'd3, 4'd0};
        lift_idle = 4'hF;
        assign_ready = 4'b0100;
        hall_dn[7] = 1'b1;
        tick();
        hall_dn = '0;
        chk_eq("single_latch", pend_dn[7], 1'b1);
        wait_valid("single_offer", 40);
        chk_eq("single_lift", assign_lift, 2'd2);
        chk_eq("single_floor", assign_floor, 4'd7);
        chk_eq("single_dir", assign_dir, 1'b0);
        tick();
        chk_eq("single_acc", assign_valid, 1'b0);
        repeat (5) tick();
        chk_eq("single_noreoffer", assign_valid, 1'b0);
        chk_eq("single_pend_held", pend_dn[7], 1'b1);
        clear_dn[7] = 1'b1;
        tick();
        clear_dn = '0;
        chk_eq("single_pend_clr", pend_dn[7], 1'b0);

        // Tie-break: cars at 4 and 6 for a call at 5; out-of-range floors on cars 2/3
        do_reset();
        lift_floor = {4'd15, 4'd12, 4'd6, 4'd4};
        lift_idle = 4'hF;
        assign_ready = 4'b0001;
        hall_up[5] = 1'b1;
        tick();
        hall_up = '0;
        wait_valid("tie_offer", 40);
        chk_eq("tie_lift", assign_lift, 2'd0);
        tick();

        // No idle car, then car 3 becomes idle
        do_reset();
        lift_floor = {4'd8, 4'd0, 4'd0, 4'd0};
        hall_up[2] = 1'b1;
        tick();
        hall_up = '0;
        vcnt = 0;
        repeat (50) begin
            tick();
            if (assign_valid) vcnt++;
        end
        chk_eq("noidle_cnt", vcnt, 0);
        lift_idle = 4'b1000;
        assign_ready = 4'b1000;
        wait_valid("idle3_offer", 24);
        chk_eq("idle3_lift", assign_lift, 2'd3);
        tick();

        // Timeout, re-offer, then clear during the re-offer
        do_reset();
        lift_idle = 4'hF;
        hall_up[1] = 1'b1;
        tick();
        hall_up = '0;
        wait_valid("to_offer", 40);
        vcnt = 1;
        tcnt = 0;
        repeat (20) begin
            tick();
            if (assign_valid) vcnt++;
            if (timeout_err) tcnt++;
        end
        chk_eq("to_valid_cycles", vcnt, 16);
        chk_eq("to_err_pulses", tcnt, 1);
        chk_eq("to_pend_kept", pend_up[1], 1'b1);
        wait_valid("to_reoffer", 30);
        chk_eq("to_reoffer_floor", assign_floor, 4'd1);
        chk_eq("to_reoffer_dir", assign_dir, 1'b1);
        clear_up[1] = 1'b1;
        tick();
        clear_up = '0;
        chk_eq("clr_withdraw", assign_valid, 1'b0);
        chk_eq("clr_pend", pend_up[1], 1'b0);

        // Round robin: pointer at 4, calls at slots 3 and 20
        do_reset();
        lift_idle = 4'hF;
        assign_ready = 4'hF;
        repeat (4) tick();
        hall_up[1] = 1'b1;
        hall_dn[10] = 1'b1;
        tick();
        hall_up = '0;
        hall_dn = '0;
        wait_valid("rr_first", 40);
        chk_eq("rr_first_floor", assign_floor, 4'd10);
        chk_eq("rr_first_dir", assign_dir, 1'b0);
        tick();
        wait_valid("rr_second", 40);
        chk_eq("rr_second_floor", assign_floor, 4'd1);
        chk_eq("rr_second_dir", assign_dir, 1'b1);
        tick();

        // Invalid buttons are never latched
        do_reset();
        lift_idle = 4'hF;
        hall_up[10] = 1'b1;
        hall_dn[0] = 1'b1;
        vcnt = 0;
        repeat (30) begin
            tick();
            if (assign_valid || pend_up[10] || pend_dn[0]) vcnt++;
        end
        chk_eq("invalid_btn", vcnt, 0);
        hall_up = '0;
        hall_dn = '0;

        // Randomized traffic against the model, including resets mid-offer
        do_reset();
        mode = 0;
        for (int cyc = 0; cyc < 4000; cyc++) begin
            if (cyc % 250 == 0) mode = $urandom_range(0, 2);
            rst = ($urandom_range(0, 499) == 0);
            hall_up  = sparse(2);
            hall_dn  = sparse(2);
            clear_up = sparse(mode == 2 ? 6 : 2);
            clear_dn = sparse(mode == 2 ? 6 : 2);
            for (int k = 0; k < 4; k++) lift_floor[4*k +: 4] = 4'($urandom_range(0, 12));
            lift_idle = 4'($urandom);
            if (mode == 1) assign_ready = '0;
            else assign_ready = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
            tick();
        end
        rst = 1'b0;
        quiet_inputs();
        tick();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
